pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the CPU's fixed 16-bit combinational adder.
- Splits the WIDTH-bit carry chain into STAGES registered segments.
- Supports add, subtract, carry/borrow chaining and optional signed saturation, and produces NZCV flags.
- Uses valid/ready handshakes on input and output, so it can sit in the multi-cycle datapath / ALU path.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, pipeline depth (= latency) and number of carry-chain segments; 1..WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  unit accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- cin  input  1  carry-in for ADC/SBB; ignored for ADD/SUB.
- sat  input  1  1 = signed saturate the result on overflow.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  sum/difference.
- flag_n  output  1  result[WIDTH-1].
- flag_z  output  1  result == 0.
- flag_c  output  1  carry out of MSB; for subtraction 1 = no borrow.
- flag_v  output  1  signed overflow of the unsaturated sum.

Behaviour:
- Operation definitions, with effective operand B' and carry c0:
  - ADD: B' = b, c0 = 0.
  - SUB: B' = ~b, c0 = 1.
  - ADC: B' = b, c0 = cin.
  - SBB: B' = ~b, c0 = cin.
  - Sum = a + B' + c0, computed at WIDTH+1 bits; flag_c = bit WIDTH.
- Segmentation:
  - SEG = WIDTH/STAGES.
  - Stage k adds bits [k*SEG +: SEG] using the carry registered by stage k-1 (c0 for k = 0).
  - Upper operand segments are delayed (skewed) k cycles; completed lower result segments are delayed to align at the output.
- Overflow: flag_v = (a[MSB] == B'[MSB]) && (sum[MSB] != a[MSB]). sat and op travel with the data.
- Saturation: if sat && flag_v, result = 0111..1 when a[MSB] == 0, else 1000..0. flag_v stays 1; flag_c is unchanged (raw carry).
- Flag timing: flag_n and flag_z are taken from the final, post-saturation result. All outputs are registered together in the last stage.
- Latency: exactly STAGES cycles from an accepted transfer (in_valid && in_ready) to out_valid, absent stalls. Throughput is 1 op/cycle.
- Stall rule:
  - advance = !out_valid || out_ready.
  - All stage registers, including valid bits, update only when advance = 1.
  - in_ready = advance (combinational from out_valid/out_ready).
  - Bubbles are not compressed during a stall.
- Output handshake:
  - result and flags hold stable while out_valid && !out_ready.
  - out_valid drops only after a transfer with no new data behind it.
- Simultaneous out transfer and in accept in the same cycle is legal; no loss, no duplication.
- Results are delivered in acceptance order.
- Reset:
  - rst asserted at any time clears all stage valid bits, out_valid, result and all flags to 0 asynchronously.
  - Operations in flight are discarded, never emitted.
  - in_ready = 1 in reset state (out_valid = 0).
- STAGES = 1: single registered adder, latency 1.
- STAGES = WIDTH: 1-bit segments, latency WIDTH.

Test Plan:
- WIDTH=16, STAGES=2, ADD a=0x00FF b=0x0001, out_ready=1 -> 2 cycles later result=0x0100, N=0 Z=0 C=0 V=0. Checks the carry crossing the bit7/bit8 segment boundary.
- ADD 0x7FFF+0x0001: sat=0 -> result=0x8000, N=1 V=1 C=0. sat=1 -> result=0x7FFF, N=0 V=1.
- SUB 0x0005-0x0005 -> 0x0000, Z=1 C=1 V=0. SBB 0x0000-0x0001 with cin=1 -> 0xFFFF, N=1 C=0. SUB 0x8000-0x0001 with sat=1 -> 0x8000, V=1.
- ADD 0xFFFF+0x0001 -> 0x0000, Z=1 C=1 V=0. ADC 0xFFFF+0x0000 with cin=1 -> same result.
- Stream 5 ops back-to-back with out_ready=0 for cycles 3-5:
  - in_ready falls the cycle out_valid && !out_ready holds.
  - result is stable through the stall.
  - all 5 results emerge in order with no duplicates.
- Accept 2 ops, assert rst one cycle later:
  - out_valid, result and flags read 0 immediately.
  - after rst is released, nothing is emitted until a new op is accepted.

Source files
------------

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Parametrised add/subtract unit with the WIDTH-bit carry chain split into
// STAGES registered segments of SEG = WIDTH/STAGES bits. It produces NZCV flags
// and can saturate signed results. Valid/ready handshakes on both sides let the
// unit stall in place.
//
// Parameters
//   WIDTH   operand/result width; must be divisible by STAGES
//   STAGES  pipeline depth (= latency) and number of carry segments, 1..WIDTH
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set present
//   in_ready   out  operands accepted this cycle (= pipeline may advance)
//   a, b       in   operands, WIDTH bits
//   op         in   00 ADD, 01 SUB, 10 ADC, 11 SBB
//   cin        in   carry-in for ADC/SBB, ignored for ADD/SUB
//   sat        in   1 = saturate the signed result on overflow
//   out_valid  out  result/flags valid
//   out_ready  in   consumer takes the result this cycle
//   result     out  sum/difference, WIDTH bits
//   flag_n     out  result MSB
//   flag_z     out  result == 0
//   flag_c     out  carry out of MSB (1 = no borrow for subtraction)
//   flag_v     out  signed overflow of the unsaturated sum
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int SEG = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    // One pipeline slot. The operand vectors stay full width: upper segments
    // are the skewed operands still waiting to be added, and lower segments of
    // sum are completed result bits travelling towards the output.
    typedef struct packed {
        logic             vld;
        logic             sat;
        logic             c;      // carry into the next segment
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;      // effective operand B'
        logic [WIDTH-1:0] sum;
    } stage_t;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_n;
    logic             r_flag_z;
    logic             r_flag_c;
    logic             r_flag_v;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    stage_t           w_stg_in [STAGES];   // slot presented to stage k

    // The whole pipe moves as one; bubbles are kept during a stall.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // NOTE: defaults are assigned before the case so every path drives both
    // outputs and no latch is inferred.
    always_comb begin
        w_b_eff = b;
        w_c0    = 1'b0;
        unique case (op_e'(op))
            OP_ADD: begin
                w_b_eff = b;
                w_c0    = 1'b0;
            end
            OP_SUB: begin
                w_b_eff = ~b;
                w_c0    = 1'b1;
            end
            OP_ADC: begin
                w_b_eff = b;
                w_c0    = cin;
            end
            OP_SBB: begin
                w_b_eff = ~b;
                w_c0    = cin;
            end
        endcase
    end

    assign w_stg_in[0] = '{vld: in_valid, sat: sat, c: w_c0,
                           a: a, b: w_b_eff, sum: '0};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG:0] w_seg;
        stage_t       w_out;

        // Segment k of the carry chain, fed by the carry registered by k-1.
        assign w_seg = {1'b0, w_stg_in[k].a[k*SEG +: SEG]}
                     + {1'b0, w_stg_in[k].b[k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_stg_in[k].c};

        always_comb begin
            w_out                  = w_stg_in[k];
            w_out.sum[k*SEG +: SEG] = w_seg[SEG-1:0];
            w_out.c                = w_seg[SEG];
        end

        if (k < STAGES - 1) begin : g_reg
            stage_t r_stg;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of its neighbours. The slot
            // payload is reset along with the valid bit so bubbles carry
            // deterministic contents.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stg <= '0;
                end else if (w_advance) begin
                    r_stg <= w_out;
                end
            end

            assign w_stg_in[k+1] = r_stg;
        end else begin : g_out
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;

            // Overflow of a + B' + c0: operands agree in sign, sum does not.
            assign w_ovf = (w_out.a[MSB] == w_out.b[MSB])
                        && (w_out.sum[MSB] != w_out.a[MSB]);

            // Positive overflow is only possible with a >= 0, so a's sign
            // selects the clamp value.
            always_comb begin
                w_res = w_out.sum;
                if (w_out.sat && w_ovf) begin
                    w_res = w_out.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            // Data registers load only with a valid op so the last result
            // stays put after out_valid drops.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_result    <= '0;
                    r_flag_n    <= 1'b0;
                    r_flag_z    <= 1'b0;
                    r_flag_c    <= 1'b0;
                    r_flag_v    <= 1'b0;
                end else if (w_advance) begin
                    r_out_valid <= w_out.vld;
                    if (w_out.vld) begin
                        r_result <= w_res;
                        r_flag_n <= w_res[MSB];
                        r_flag_z <= (w_res == '0);
                        r_flag_c <= w_out.c;
                        r_flag_v <= w_ovf;
                    end
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;

endmodule
